// File: rtl/rf_pkg.sv
// rf_pkg: shared types and constants for the RF frame transmit scheduler.
// Frame formats, FSM states and default geometry.
package rf_pkg;

  typedef enum logic {
    FMT64 = 1'b0,
    FMT16 = 1'b1
  } rf_fmt_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEL,
    ST_CAPT,
    ST_SEND,
    ST_GAP
  } rf_state_e;

  localparam int F0_ROWS = 8;
  localparam int F1_ROWS = 4;
  localparam int ROW_W   = 10;

endpackage

// File: rtl/rf_rr_arb2.sv
// rf_rr_arb2: two-requester round-robin arbiter.
// The last-grant register only moves when the winner is actually granted.
module rf_rr_arb2
  import rf_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    req64,
  input  logic    req16,
  input  logic    upd,
  input  rf_fmt_e upd_fmt,
  output logic    any_req,
  output rf_fmt_e win
);

  rf_fmt_e last_q, last_d;

  always_comb begin
    any_req = req64 | req16;
    win     = FMT64;
    unique case (1'b1)
      req64 && req16:
        win = (last_q == FMT64) ? FMT16 : FMT64;
      req16 && !req64:
        win = FMT16;
      default:
        win = FMT64;
    endcase
    last_d = upd ? upd_fmt : last_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= FMT64;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/rf_frame_tx_sched.sv
// rf_frame_tx_sched: arbitrates data/header frames, drives the scrambler, streams rows.
// Define RF_ERR_INJ_ONESHOT_EN for edge-armed, single-frame error injection.
module rf_frame_tx_sched
  import rf_pkg::*;
#(
  parameter int DATA_WIDTH = rf_pkg::ROW_W,
  parameter int DATA_DEPTH = rf_pkg::F0_ROWS,
  parameter int F1_ROWS    = rf_pkg::F1_ROWS,
  parameter int GAP_CYCLES = 2
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 req64,
  input  logic                                 req16,
  output logic                                 gnt64,
  output logic                                 gnt16,
  output logic                                 enc_used,
  output logic                                 err_inj_enable,
  input  logic                                 err_inj_arm,
  input  logic [DATA_DEPTH-1:0][DATA_WIDTH-1:0] par_in,
  output logic [DATA_WIDTH-1:0]                row_data,
  output logic                                 row_valid,
  input  logic                                 row_ready,
  output logic                                 row_sof,
  output logic                                 row_eof,
  output logic                                 busy,
  output logic [15:0]                          frame_cnt
`ifdef RF_ERR_INJ_ONESHOT_EN
  ,
  output logic                                 err_inj_done
`endif
);

  localparam int IW = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [IW-1:0] LAST0 = IW'(DATA_DEPTH - 1);
  localparam logic [IW-1:0] LAST1 = IW'(F1_ROWS - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  typedef logic [DATA_DEPTH-1:0][DATA_WIDTH-1:0] frame_t;

  rf_state_e             state_q, state_d;
  rf_fmt_e               fmt_q, fmt_d, win;
  logic                  any_req, arm_take;
  logic [IW-1:0]         idx_q, idx_d, idx_nxt, last_idx;
  logic [GW-1:0]         gap_q, gap_d;
  frame_t                fbuf_q, fbuf_d;
  logic [DATA_WIDTH-1:0] row_data_q, row_data_d;
  logic                  row_valid_q, row_valid_d;
  logic                  sof_q, sof_d, eof_q, eof_d;
  logic                  gnt64_q, gnt64_d;
  logic                  gnt16_q, gnt16_d;
  logic                  enc_q, enc_d, err_q, err_d;
  logic                  busy_q, busy_d;
  logic [15:0]           frame_cnt_q, frame_cnt_d;

`ifdef RF_ERR_INJ_ONESHOT_EN
  logic arm_prev_q, armed_q, armed_d;
  logic done_q, done_d, arm_rise;
  assign arm_rise = err_inj_arm & ~arm_prev_q;
  assign arm_take = armed_q | arm_rise;
`else
  assign arm_take = err_inj_arm;
`endif

  rf_rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req64   (req64),
    .req16   (req16),
    .upd     (gnt64_q | gnt16_q),
    .upd_fmt (fmt_q),
    .any_req (any_req),
    .win     (win)
  );

  always_comb begin
    state_d     = state_q;
    fmt_d       = fmt_q;
    idx_d       = idx_q;
    gap_d       = gap_q;
    fbuf_d      = fbuf_q;
    row_data_d  = row_data_q;
    row_valid_d = row_valid_q;
    sof_d       = sof_q;
    eof_d       = eof_q;
    gnt64_d     = 1'b0;
    gnt16_d     = 1'b0;
    enc_d       = enc_q;
    err_d       = err_q;
    frame_cnt_d = frame_cnt_q;
    idx_nxt     = idx_q + IW'(1);
    last_idx    = (fmt_q == FMT16) ? LAST1 : LAST0;
`ifdef RF_ERR_INJ_ONESHOT_EN
    armed_d     = arm_take;
    done_d      = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        enc_d = 1'b0;
        err_d = 1'b0;
        if (any_req) begin
          state_d = ST_SEL;
          fmt_d   = win;
          enc_d   = (win == FMT16);
          err_d   = arm_take;
`ifdef RF_ERR_INJ_ONESHOT_EN
          armed_d = 1'b0;
`endif
        end
      end
      ST_SEL: begin
        state_d = ST_CAPT;
        gnt64_d = (fmt_q == FMT64);
        gnt16_d = (fmt_q == FMT16);
`ifdef RF_ERR_INJ_ONESHOT_EN
        done_d  = err_q;
`endif
      end
      ST_CAPT: begin
        state_d     = ST_SEND;
        fbuf_d      = par_in;
        idx_d       = '0;
        row_data_d  = par_in[0];
        row_valid_d = 1'b1;
        sof_d       = 1'b1;
        eof_d       = (last_idx == '0);
        err_d       = 1'b0;
      end
      ST_SEND: begin
        if (row_ready) begin
          if (idx_q == last_idx) begin
            row_valid_d = 1'b0;
            row_data_d  = '0;
            sof_d       = 1'b0;
            eof_d       = 1'b0;
            gap_d       = '0;
            frame_cnt_d = frame_cnt_q + 16'd1;
            if (GAP_CYCLES == 0) begin
              state_d = ST_IDLE;
              enc_d   = 1'b0;
            end else begin
              state_d = ST_GAP;
            end
          end else begin
            idx_d      = idx_nxt;
            row_data_d = fbuf_q[idx_nxt];
            sof_d      = 1'b0;
            eof_d      = (idx_nxt == last_idx);
          end
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = ST_IDLE;
          enc_d   = 1'b0;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      fmt_q       <= FMT64;
      idx_q       <= '0;
      gap_q       <= '0;
      fbuf_q      <= '0;
      row_data_q  <= '0;
      row_valid_q <= 1'b0;
      sof_q       <= 1'b0;
      eof_q       <= 1'b0;
      gnt64_q     <= 1'b0;
      gnt16_q     <= 1'b0;
      enc_q       <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      frame_cnt_q <= '0;
`ifdef RF_ERR_INJ_ONESHOT_EN
      arm_prev_q  <= 1'b0;
      armed_q     <= 1'b0;
      done_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      fmt_q       <= fmt_d;
      idx_q       <= idx_d;
      gap_q       <= gap_d;
      fbuf_q      <= fbuf_d;
      row_data_q  <= row_data_d;
      row_valid_q <= row_valid_d;
      sof_q       <= sof_d;
      eof_q       <= eof_d;
      gnt64_q     <= gnt64_d;
      gnt16_q     <= gnt16_d;
      enc_q       <= enc_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      frame_cnt_q <= frame_cnt_d;
`ifdef RF_ERR_INJ_ONESHOT_EN
      arm_prev_q  <= err_inj_arm;
      armed_q     <= armed_d;
      done_q      <= done_d;
`endif
    end
  end

  assign gnt64          = gnt64_q;
  assign gnt16          = gnt16_q;
  assign enc_used       = enc_q;
  assign err_inj_enable = err_q;
  assign row_data       = row_data_q;
  assign row_valid      = row_valid_q;
  assign row_sof        = sof_q;
  assign row_eof        = eof_q;
  assign busy           = busy_q;
  assign frame_cnt      = frame_cnt_q;
`ifdef RF_ERR_INJ_ONESHOT_EN
  assign err_inj_done   = done_q;
`endif

endmodule

// File: tb/tb_rf_frame_tx_sched.sv
// tb_rf_frame_tx_sched: directed frames checked against a timestamp/queue model
// of the scheduler plus hand-computed literal expectations.
module tb_rf_frame_tx_sched;

  localparam int DW  = 10;
  localparam int DD  = 8;
  localparam int F1R = 4;
  localparam int GAP = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req64 = 1'b0;
  logic req16 = 1'b0;
  logic err_inj_arm = 1'b0;
  logic row_ready = 1'b0;
  logic [DD-1:0][DW-1:0] par_in = '0;
  logic gnt64, gnt16, enc_used, err_inj_enable;
  logic row_valid, row_sof, row_eof, busy;
  logic [DW-1:0] row_data;
  logic [15:0] frame_cnt;
  logic err_inj_done;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  rf_frame_tx_sched #(
    .DATA_WIDTH (DW),
    .DATA_DEPTH (DD),
    .F1_ROWS    (F1R),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req64          (req64),
    .req16          (req16),
    .gnt64          (gnt64),
    .gnt16          (gnt16),
    .enc_used       (enc_used),
    .err_inj_enable (err_inj_enable),
    .err_inj_arm    (err_inj_arm),
    .par_in         (par_in),
    .row_data       (row_data),
    .row_valid      (row_valid),
    .row_ready      (row_ready),
    .row_sof        (row_sof),
    .row_eof        (row_eof),
    .busy           (busy),
    .frame_cnt      (frame_cnt)
`ifdef RF_ERR_INJ_ONESHOT_EN
    ,
    .err_inj_done   (err_inj_done)
`endif
  );

`ifndef RF_ERR_INJ_ONESHOT_EN
  assign err_inj_done = 1'b0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: a frame is a decision cycle, a SEL timestamp, a row queue and
  // an idle timestamp once the last row has been accepted.
  bit m_act, m_send, m_done, m_fmt, m_err, m_last;
  bit m_armed, m_arm_prev, m_rise, e_sel, e_capt;
  int m_sel, m_idle_at, m_sent;
  logic [15:0] m_cnt;
  logic [DW-1:0] m_q[$];

  logic [DW-1:0] obs_rows[$];
  int obs_gnt[$];
  int first_v = -1;
  int eof_cyc = -1;
  int err_cyc = 0;
  int done_n = 0;
  int hold_n = 0;
  logic [DW-1:0] sof_val, eof_val, pd;
  bit pv, pr;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_act = 0; m_send = 0; m_done = 0; m_last = 0;
      m_cnt = 0; m_armed = 0; m_arm_prev = 0; pv = 0;
      m_q.delete();
      chk("rst_valid", row_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_gnt", {gnt64, gnt16}, 0);
      chk("rst_enc", enc_used, 0);
      chk("rst_err", err_inj_enable, 0);
      chk("rst_data", row_data, 0);
      chk("rst_sofeof", {row_sof, row_eof}, 0);
      chk("rst_cnt", frame_cnt, 0);
    end else begin
      e_sel  = m_act && (cyc == m_sel);
      e_capt = m_act && (cyc == m_sel + 1);
      chk("busy", busy, m_act);
      chk("enc_used", enc_used, m_act && m_fmt);
      chk("err_en", err_inj_enable, (e_sel || e_capt) && m_err);
      chk("gnt64", gnt64, e_capt && !m_fmt);
      chk("gnt16", gnt16, e_capt && m_fmt);
      chk("row_valid", row_valid, m_send);
      chk("frame_cnt", frame_cnt, m_cnt);
      if (m_send) begin
        chk("row_data", row_data, m_q[0]);
        chk("row_sof", row_sof, m_sent == 0);
        chk("row_eof", row_eof, m_q.size() == 1);
      end else begin
        chk("sofeof_off", {row_sof, row_eof}, 0);
      end
`ifdef RF_ERR_INJ_ONESHOT_EN
      chk("err_done", err_inj_done, e_capt && m_err);
`endif
      if (err_inj_done) done_n++;
      if (err_inj_enable) err_cyc++;
      if (gnt64) obs_gnt.push_back(64);
      if (gnt16) obs_gnt.push_back(16);
      if (row_valid && first_v < 0) first_v = cyc;
      if (pv && !pr) begin
        hold_n++;
        chk("hold_valid", row_valid, 1);
        chk("hold_data", row_data, pd);
      end
      if (row_valid && row_ready) begin
        obs_rows.push_back(row_data);
        if (row_sof) sof_val = row_data;
        if (row_eof) begin
          eof_val = row_data;
          eof_cyc = cyc;
        end
      end
      pv = row_valid; pr = row_ready; pd = row_data;

      m_rise = err_inj_arm && !m_arm_prev;
      if (!m_act && (req64 || req16)) begin
        m_fmt = (req64 && req16) ? !m_last : req16;
        m_last = m_fmt;
`ifdef RF_ERR_INJ_ONESHOT_EN
        m_err = m_armed || m_rise;
        m_armed = 0;
`else
        m_err = err_inj_arm;
`endif
        m_act = 1; m_sel = cyc + 1; m_done = 0; m_send = 0;
      end else begin
`ifdef RF_ERR_INJ_ONESHOT_EN
        m_armed = m_armed || m_rise;
`endif
        if (e_capt) begin
          m_q.delete();
          for (int i = 0; i < (m_fmt ? F1R : DD); i++)
            m_q.push_back(par_in[i]);
          m_send = 1; m_sent = 0;
        end else if (m_send && row_ready) begin
          void'(m_q.pop_front());
          m_sent++;
          if (m_q.size() == 0) begin
            m_send = 0; m_done = 1; m_cnt++;
            m_idle_at = cyc + 1 + GAP;
          end
        end
      end
      if (m_act && m_done && cyc + 1 >= m_idle_at) m_act = 0;
      m_arm_prev = err_inj_arm;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(input bit is16, output int at);
    int k = 0;
    while (!(is16 ? gnt16 : gnt64) && k < 30) begin
      tick();
      k++;
    end
    at = cyc;
    chk(is16 ? "gnt16_seen" : "gnt64_seen", is16 ? gnt16 : gnt64, 1);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 200) begin
      tick();
      k++;
    end
    chk("idle_reached", busy, 0);
  endtask

  task automatic set_rows(input int base);
    for (int i = 0; i < DD; i++) par_in[i] = DW'(base + i);
  endtask

  task automatic chk_rows(input string nm, input int base, input int n);
    chk({nm, "_count"}, obs_rows.size(), n);
    for (int i = 0; i < n; i++)
      chk(nm, (i < obs_rows.size()) ? obs_rows[i] : 32'hFFFF, base + i);
  endtask

  task automatic one_frame64();
    int tg;
    req64 = 1'b1;
    wait_gnt(0, tg);
    req64 = 1'b0;
    wait_idle();
  endtask

  int t0, tg, k;
  bit started;
  bit pat[4];

  initial begin
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    repeat (3) tick();
    chk("init_busy", busy, 0);
    chk("init_cnt", frame_cnt, 0);
    rst_n = 1'b1;
    tick();

    // single data frame, rows 0..7
    set_rows(0);
    row_ready = 1'b1;
    obs_rows.delete(); first_v = -1;
    req64 = 1'b1; t0 = cyc;
    wait_gnt(0, tg);
    req64 = 1'b0;
    chk("f1_gnt_lat", tg - t0, 2);
    wait_idle();
    chk("f1_valid_lat", first_v - t0, 3);
    chk_rows("f1_row", 0, 8);
    chk("f1_sof", sof_val, 10'h000);
    chk("f1_eof", eof_val, 10'h007);
    chk("f1_cnt", frame_cnt, 1);

    // header frame, 4 rows then the gap
    set_rows(0);
    for (int i = 0; i < F1R; i++) par_in[i] = DW'(10'h3A0 + i);
    obs_rows.delete();
    req16 = 1'b1;
    tick();
    chk("f2_enc_sel", enc_used, 1);
    wait_gnt(1, tg);
    req16 = 1'b0;
    chk("f2_enc_capt", enc_used, 1);
    wait_idle();
    chk_rows("f2_row", 10'h3A0, 4);
    chk("f2_eof", eof_val, 10'h3A3);
    chk("f2_gap", cyc - eof_cyc, GAP + 1);
    chk("f2_enc_idle", enc_used, 0);
    chk("f2_cnt", frame_cnt, 2);

    // round robin from reset with both requests held
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    chk("f3_cnt_rst", frame_cnt, 0);
    set_rows(10'h050);
    obs_gnt.delete();
    req64 = 1'b1; req16 = 1'b1;
    k = 0;
    while (obs_gnt.size() < 4 && k < 200) begin
      tick();
      k++;
    end
    req64 = 1'b0; req16 = 1'b0;
    wait_idle();
    chk("f3_ngnt", obs_gnt.size(), 4);
    for (int i = 0; i < 4; i++)
      chk("f3_order", (i < obs_gnt.size()) ? obs_gnt[i] : 0,
          (i % 2 == 0) ? 16 : 64);
    chk("f3_cnt", frame_cnt, 4);

    // backpressure with ready pattern 1,0,0,1
    set_rows(10'h100);
    obs_rows.delete(); hold_n = 0;
    req64 = 1'b1; row_ready = 1'b1;
    k = 0; started = 0;
    do begin
      tick();
      k++;
      if (gnt64) req64 = 1'b0;
      if (busy) started = 1;
      row_ready = pat[k % 4];
    end while ((!started || busy) && k < 300);
    row_ready = 1'b1;
    chk("f4_done", busy, 0);
    chk_rows("f4_row", 10'h100, 8);
    chk("f4_hold_seen", hold_n != 0, 1);
    chk("f4_cnt", frame_cnt, 5);

    // error injection armed across two frames
    set_rows(10'h180);
    err_cyc = 0; done_n = 0;
    err_inj_arm = 1'b1;
    tick();
    one_frame64();
    one_frame64();
    err_inj_arm = 1'b0;
`ifdef RF_ERR_INJ_ONESHOT_EN
    chk("f5_err_cycles", err_cyc, 2);
    chk("f5_done_pulses", done_n, 1);
`else
    chk("f5_err_cycles", err_cyc, 4);
    chk("f5_done_pulses", done_n, 0);
`endif
    chk("f5_cnt", frame_cnt, 7);

    // reset while row 4 of a data frame is on the bus
    set_rows(10'h200);
    req64 = 1'b1;
    k = 0;
    while (!(row_valid && row_data == 10'h204) && k < 50) begin
      tick();
      k++;
    end
    chk("f6_row4_reached", row_data, 10'h204);
    rst_n = 1'b0;
    #1;
    chk("f6_valid", row_valid, 0);
    chk("f6_data", row_data, 0);
    chk("f6_busy", busy, 0);
    chk("f6_cnt", frame_cnt, 0);
    chk("f6_enc", enc_used, 0);
    chk("f6_flags", {gnt64, gnt16, row_sof, row_eof}, 0);
    tick(); tick();
    obs_rows.delete(); obs_gnt.delete();
    rst_n = 1'b1;
    wait_gnt(0, tg);
    req64 = 1'b0;
    wait_idle();
    chk("f6_ngnt", obs_gnt.size(), 1);
    chk_rows("f6_row", 10'h200, 8);
    chk("f6_cnt_after", frame_cnt, 1);

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rf_frame_tx_sched.md
Name: rf_frame_tx_sched

Overview:
- Sequences the RF packet scrambler and feeds its rows to the serializer.
- Arbitrates between two frame requesters:
  - 64-bit data frame (format0, 8 rows x 10 bits).
  - 16-bit header frame (format1, 4 rows used).
- Drives the scrambler's enc_used and error-injection controls, captures the scrambled parallel frame, then streams it row by row over a valid/ready handshake.
- Sits between the FEC engine / scrambler and the serializer.

Parameters:
- DATA_WIDTH, 10, bits per row.
- DATA_DEPTH, 8, max rows per frame (format0).
- F1_ROWS, 4, rows sent for format1.
- GAP_CYCLES, 2, idle cycles enforced between frames (0 allowed).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req64  in  1  data frame ready at FEC outputs; held until gnt64.
- req16  in  1  header frame ready; held until gnt16.
- gnt64  out  1  one-cycle pulse: data frame accepted.
- gnt16  out  1  one-cycle pulse: header frame accepted.
- enc_used  out  1  to scrambler: 0 = format0, 1 = format1.
- err_inj_enable  out  1  to scrambler.
- err_inj_arm  in  1  request to inject errors on frames.
- par_in  in  DATA_DEPTH x DATA_WIDTH  scrambler par_out.
- row_data  out  DATA_WIDTH  row to serializer.
- row_valid  out  1  row_data valid.
- row_ready  in  1  serializer accepts row.
- row_sof  out  1  qualifies first row of frame.
- row_eof  out  1  qualifies last row of frame.
- busy  out  1  FSM not in IDLE.
- frame_cnt  out  16  frames completed, wraps 0xFFFF -> 0.

Behaviour:
- Reset: all outputs 0. FSM = IDLE, last-grant flag = 64, gap counter = 0, frame_cnt = 0.
- States: IDLE, SEL, CAPT, SEND, GAP.
- IDLE, arbitration when any request is pending:
  - Only one request pending: that request wins.
  - Both pending: round-robin; the requester not granted last wins. After reset the tie goes to req16.
  - Winner fixes enc_used (1 for req16); go to SEL.
- SEL (1 cycle): enc_used and err_inj_enable are driven stable so the combinational scrambler settles; go to CAPT.
- CAPT (1 cycle):
  - par_in is registered into the frame buffer.
  - The gnt pulse for the winner is issued in this cycle; the requester may change FEC outputs the next cycle.
  - Row index := 0. Go to SEND.
- SEND:
  - row_valid = 1. row_data = buffer[row index]; row 0 first, LSB-aligned.
  - row_sof while row index = 0. row_eof while row index = last (7 for format0, F1_ROWS-1 for format1).
  - Row advances only on row_valid & row_ready. row_data is held stable while row_ready = 0.
  - Handshake on the eof row: frame_cnt += 1, then go to GAP, or to IDLE if GAP_CYCLES = 0.
- GAP: count GAP_CYCLES cycles with row_valid = 0, then go to IDLE.
- Latency: request seen in IDLE -> first row_valid = 3 cycles (IDLE -> SEL -> CAPT -> SEND).
- Throughput: one row per cycle with row_ready held high.
- err_inj_enable:
  - Equals err_inj_arm sampled on entry to SEL.
  - Held constant through CAPT; 0 in all other states.
- Requests arriving or dropping while busy are ignored until IDLE. A request dropped before grant is never granted.
- enc_used holds its value from SEL through end of GAP and returns to 0 in IDLE.
- rst_n asserted mid-frame: immediate abort, all outputs 0, partial frame is not counted, no gnt issued.
- row_ready may be asserted without row_valid; it has no effect.

Optional Feature:
- Macro: RF_ERR_INJ_ONESHOT_EN.
- Defined:
  - A rising edge on err_inj_arm sets an internal armed flag.
  - The next frame entering SEL consumes the flag and injects; later frames do not inject until the next rising edge.
  - Port err_inj_done (out, 1) pulses for one cycle in CAPT of the injected frame.
- Not defined:
  - err_inj_arm is level-sampled, as in Behaviour.
  - err_inj_done does not exist.

Decomposition:
- Shared package rf_pkg:
  - typedef rf_fmt_e {FMT64 = 0, FMT16 = 1}.
  - FSM state enum.
  - Constants F0_ROWS = 8, F1_ROWS = 4, ROW_W = 10.
- Sub-module rf_rr_arb2: 2-requester round-robin arbiter with last-grant register and update-on-grant input.
- Everything else stays in rf_frame_tx_sched.

Test Plan:
- Single req64, row_ready = 1, par_in rows = 0x000..0x007:
  - 8 consecutive rows 0x000..0x007.
  - sof on row 0, eof on row 7.
  - gnt64 exactly 2 cycles after request seen; frame_cnt = 1.
- req16 alone, par_in rows 0x3A0..0x3A3:
  - enc_used = 1 from SEL.
  - 4 rows sent, eof on row 3.
  - Then GAP_CYCLES idle cycles; enc_used returns to 0.
- req16 and req64 held simultaneously for 4 frames from reset: grant order 16, 64, 16, 64.
- Backpressure: row_ready toggling 1,0,0,1 during format0 send: row_data stable during low cycles; no row skipped or duplicated.
- err_inj_arm = 1 across two frames:
  - Without macro: err_inj_enable high in SEL/CAPT of both frames.
  - With RF_ERR_INJ_ONESHOT_EN: only the first frame, with err_inj_done pulsing once.
- rst_n low at row 4 of a format0 frame: outputs 0 asynchronously, frame_cnt = 0. After release with req64 still high, the full 8-row frame is resent.
